mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port, variable-latency memory between the CPU's instruction-fetch requester (I) and load/store requester (D).
- Sits between the fetch/load-store logic and the memory model, one arbitrated transaction at a time.
- Round-robin grant; the memory side uses a req/ack handshake.
- Requesters see a one-cycle ack pulse with read data or a timeout error.

Parameters:
- ADDR_W, 32, address width for both requesters and the memory.
- DATA_W, 32, data width (cpu_word).
- TIMEOUT, 64, maximum cycles in BUSY without mem_ack before abort; legal range 2..2^16-1.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- i_req / d_req  in  1  request; held high until the matching ack
- i_addr / d_addr  in  ADDR_W  address; stable while req is high
- d_wdata  in  DATA_W  store data
- d_we  in  1  1 = store, 0 = load
- d_mode  in  2  access size (mem_mode encoding)
- i_ack / d_ack  out  1  one-cycle completion pulse
- i_err / d_err  out  1  valid with ack; 1 = timeout
- i_rdata / d_rdata  out  DATA_W  read data, valid while ack is high
- mem_req  out  1  transaction active
- mem_addr  out  ADDR_W  latched address
- mem_wdata  out  DATA_W  latched write data
- mem_we  out  1  latched write enable
- mem_mode  out  2  latched size; word for I
- mem_ack  in  1  memory completion; may assert in the first mem_req cycle
- mem_rdata  in  DATA_W  valid with mem_ack

Behaviour:
- Reset:
  - All outputs 0, state IDLE, timeout counter 0.
  - Priority pointer favours D (last_grant = I).
  - Reset asserted mid-transaction aborts it silently: no ack; mem_req drops asynchronously.
- States are IDLE, BUSY_I and BUSY_D. The state is registered; mem_* outputs are driven from registers.
- IDLE:
  - Eligible requester: req high and its ack not asserted in the current cycle. This masks the requester's still-high req in its ack cycle.
  - One eligible requester: grant it.
  - Both eligible: grant the one not in last_grant.
  - On grant at edge N:
    - State becomes BUSY_x at N+1.
    - mem_req=1 from N+1.
    - mem_addr/wdata/we/mode latched from x.
    - For I: we=0, wdata=0, mode=word.
    - last_grant=x, counter=0.
  - Grant-to-mem_req latency is 1 cycle.
- BUSY_x:
  - mem_req stays high and latched fields stay constant; requester inputs are ignored.
  - Counter increments each cycle without mem_ack.
  - mem_ack=1 at edge M:
    - State goes to IDLE.
    - mem_req goes to 0.
    - x_ack=1, x_err=0 and x_rdata=mem_rdata are all registered, visible M+1 for one cycle.
    - d_rdata is valid for loads; it is mem_rdata for stores and don't-care.
  - Counter reaches TIMEOUT-1 with mem_ack=0:
    - State goes to IDLE and mem_req goes to 0.
    - x_ack=1, x_err=1, x_rdata=0 next cycle.
    - A mem_ack arriving in that same cycle wins: normal completion.
- Back-to-back:
  - Arbitration happens in the ack cycle (M+1) with x masked. The other requester, if pending, gets mem_req at M+2.
  - The same requester, if its req is still high at M+2, is eligible again.
- Best case, a single access is req at N, mem_req N+1, mem_ack N+1, ack N+2: 2 cycles.
- rdata holds its last value when ack is low. err is 0 whenever ack is 0.
- mem_ack in IDLE is ignored.
- A requester dropping req while BUSY is a protocol violation: the transaction completes and the ack is still pulsed.
- Never more than one ack high per cycle; mem_req never high in IDLE.

Test Plan:
- Reset then idle:
  - Stimulus: all inputs 0 for 10 cycles.
  - Required: mem_req, all acks and all errs stay 0.
- Single fetch:
  - Stimulus: i_req=1, i_addr=0x10 at N; memory acks same cycle with 0xDEADBEEF.
  - Required: mem_req=1, mem_addr=0x10, mem_we=0 at N+1; i_ack=1, i_rdata=0xDEADBEEF, i_err=0 at N+2 only.
- Simultaneous requests after reset:
  - Stimulus: i_req and d_req high at the same edge (D store 0x20←0x55, I fetch 0x0); memory latency 3 cycles.
  - Required: D granted first with mem_we=1, mem_wdata=0x55; d_ack 4 cycles after the grant; I mem_req in the d_ack cycle +1; no i_ack before d_ack.
- Round-robin fairness:
  - Stimulus: both requesters held requesting continuously for 8 transactions, latency 1.
  - Required: grants alternate D,I,D,I…; no requester is granted twice in a row.
- Timeout, TIMEOUT=4:
  - Stimulus: d_req, memory never acks.
  - Required: mem_req high exactly 4 cycles; d_ack=1, d_err=1, d_rdata=0 next cycle; state IDLE.
  - Follow-up: a subsequent i_req is served normally.
- Reset mid-transaction:
  - Stimulus: assert reset while in BUSY_I, between clock edges.
  - Required: mem_req drops immediately; no i_ack.
  - Follow-up: after release, simultaneous requests grant D first.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port, variable-latency memory between
// the instruction-fetch (I) and load/store (D) requesters. One transaction at a
// time; requesters receive a registered one-cycle ack with data or a timeout error.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  // Instruction-fetch requester
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic              i_err,
  output logic [DATA_W-1:0] i_rdata,
  // Load/store requester
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic              d_we,
  input  logic [1:0]        d_mode,
  output logic              d_ack,
  output logic              d_err,
  output logic [DATA_W-1:0] d_rdata,
  // Memory side
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic [1:0]        mem_mode,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [1:0]  ModeWord = 2'b10;
  localparam logic [15:0] CntLast  = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StBusyI, StBusyD} state_e;

  state_e            state_q, state_d;
  logic              last_d_q, last_d_d;  // 1: D was granted last
  logic [15:0]       cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [1:0]        mode_q, mode_d;
  logic              i_ack_q, i_ack_d, d_ack_q, d_ack_d;
  logic              i_err_q, i_err_d, d_err_q, d_err_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;

  logic i_elig, d_elig, grant_i, grant_d, tmo;

  // A requester is masked during its own ack cycle, since its req is still high.
  assign i_elig  = i_req && !i_ack_q;
  assign d_elig  = d_req && !d_ack_q;
  assign grant_d = d_elig && (!i_elig || !last_d_q);
  assign grant_i = i_elig && !grant_d;
  // mem_ack in the final counted cycle takes precedence over the timeout.
  assign tmo     = !mem_ack && (cnt_q == CntLast);

  // Next-state: arbitration in idle, completion/timeout handling while busy.
  always_comb begin
    state_d   = state_q;
    last_d_d  = last_d_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    mode_d    = mode_q;
    i_ack_d   = 1'b0;
    d_ack_d   = 1'b0;
    i_err_d   = 1'b0;
    d_err_d   = 1'b0;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    case (state_q)
      StIdle: begin
        if (grant_d) begin
          state_d  = StBusyD;
          last_d_d = 1'b1;
          cnt_d    = '0;
          addr_d   = d_addr;
          wdata_d  = d_wdata;
          we_d     = d_we;
          mode_d   = d_mode;
        end else if (grant_i) begin
          state_d  = StBusyI;
          last_d_d = 1'b0;
          cnt_d    = '0;
          addr_d   = i_addr;
          wdata_d  = '0;
          we_d     = 1'b0;
          mode_d   = ModeWord;
        end
      end
      StBusyI, StBusyD: begin
        if (mem_ack || tmo) begin
          state_d = StIdle;
          cnt_d   = '0;
          if (state_q == StBusyD) begin
            d_ack_d   = 1'b1;
            d_err_d   = tmo;
            d_rdata_d = mem_ack ? mem_rdata : '0;
          end else begin
            i_ack_d   = 1'b1;
            i_err_d   = tmo;
            i_rdata_d = mem_ack ? mem_rdata : '0;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers; reset aborts any transaction silently.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      last_d_q  <= 1'b0;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      mode_q    <= 2'b00;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      i_err_q   <= 1'b0;
      d_err_q   <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      last_d_q  <= last_d_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      mode_q    <= mode_d;
      i_ack_q   <= i_ack_d;
      d_ack_q   <= d_ack_d;
      i_err_q   <= i_err_d;
      d_err_q   <= d_err_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign mem_req   = (state_q != StIdle);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_we    = we_q;
  assign mem_mode  = mode_q;
  assign i_ack     = i_ack_q;
  assign i_err     = i_err_q;
  assign i_rdata   = i_rdata_q;
  assign d_ack     = d_ack_q;
  assign d_err     = d_err_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus pushes expected grants and
// acks into queues; a negedge monitor pops and compares as the DUT produces them.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;
  logic [1:0]  d_mode = 2'b00;
  logic        i_ack, i_err, d_ack, d_err;
  logic [31:0] i_rdata, d_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  mem_mode;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_err(i_err), .i_rdata(i_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_we(d_we), .d_mode(d_mode),
    .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_mode(mem_mode), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  // Memory model: acks in the lat-th mem_req cycle (lat=0: never); data from address.
  int unsigned lat = 1;
  int unsigned mcnt;
  assign mem_ack   = mem_req && (lat != 0) && (mcnt == lat - 1);
  assign mem_rdata = mem_addr ^ 32'hDEADBEFF;
  always @(posedge clk or posedge reset) begin
    if (reset) mcnt <= 0;
    else if (mem_req && !mem_ack) mcnt <= mcnt + 1;
    else mcnt <= 0;
  end

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [1:0]  mode;
    logic [31:0] len;  // expected mem_req cycles; 0 = unchecked
  } grant_t;
  typedef struct packed {
    logic        is_d;
    logic        err;
    logic [31:0] rdata;
  } ack_t;

  grant_t gq[$];
  ack_t   aq[$];
  int     n_checks = 0;
  int     n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rd(input logic [31:0] a);
    return a ^ 32'hDEADBEFF;
  endfunction

  task automatic push_g(input logic [31:0] a, input logic [31:0] w, input logic we,
                        input logic [1:0] m, input logic [31:0] len);
    grant_t g;
    g.addr = a; g.wdata = w; g.we = we; g.mode = m; g.len = len;
    gq.push_back(g);
  endtask

  task automatic push_a(input logic is_d, input logic err, input logic [31:0] r);
    ack_t x;
    x.is_d = is_d; x.err = err; x.rdata = r;
    aq.push_back(x);
  endtask

  // Monitor
  logic        prev_req = 1'b0;
  logic [31:0] run_len = 0, exp_len = 0;
  always @(negedge clk) begin
    if (reset) begin
      prev_req = 1'b0;
    end else begin
      if (i_ack && d_ack) check("two_acks", 32'(i_ack & d_ack), 32'd0);
      check("ack_follows_mem_req_fall", 32'(i_ack | d_ack), 32'(prev_req && !mem_req));
      if (!i_ack || !d_ack) check("err_without_ack",
                                  32'((i_err & !i_ack) | (d_err & !d_ack)), 32'd0);
      if (mem_req && !prev_req) begin
        if (gq.size() == 0) begin
          check("unexpected_grant", 32'd1, 32'd0);
          exp_len = 0;
        end else begin
          grant_t g;
          g = gq.pop_front();
          check("grant_addr", mem_addr, g.addr);
          check("grant_wdata", mem_wdata, g.wdata);
          check("grant_we", 32'(mem_we), 32'(g.we));
          check("grant_mode", 32'(mem_mode), 32'(g.mode));
          exp_len = g.len;
        end
        run_len = 1;
      end else if (mem_req) begin
        run_len = run_len + 1;
      end
      if (!mem_req && prev_req && exp_len != 0) check("mem_req_len", run_len, exp_len);
      if (i_ack || d_ack) begin
        if (aq.size() == 0) begin
          check("unexpected_ack", 32'd1, 32'd0);
        end else begin
          ack_t x;
          x = aq.pop_front();
          check("ack_port_is_d", 32'(d_ack), 32'(x.is_d));
          check("ack_err", 32'(d_ack ? d_err : i_err), 32'(x.err));
          check("ack_rdata", d_ack ? d_rdata : i_rdata, x.rdata);
        end
      end
      prev_req = mem_req;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until the selected ack is seen; leaves the bench in the ack cycle.
  task automatic wait_ack(input bit is_d, input int budget, input string name);
    bit seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      step();
      if (is_d ? d_ack : i_ack) seen = 1'b1;
    end
    check(name, 32'(seen), 32'd1);
  endtask

  initial begin
    int ic, dc;
    // Reset then idle
    step();
    check("reset_mem_req", 32'(mem_req), 32'd0);
    check("reset_acks", 32'({i_ack, d_ack, i_err, d_err}), 32'd0);
    check("reset_mem_addr", mem_addr, 32'd0);
    step();
    reset = 1'b0;
    for (int k = 0; k < 10; k++) step();
    check("idle_outputs", 32'({mem_req, i_ack, d_ack, i_err, d_err}), 32'd0);

    // Single fetch, memory acks in the first mem_req cycle
    lat = 1;
    i_req = 1'b1; i_addr = 32'h10;
    push_g(32'h10, 32'h0, 1'b0, 2'b10, 1);
    push_a(1'b0, 1'b0, 32'hDEADBEEF);
    step();
    check("fetch_mem_req", 32'({mem_req, mem_we}), 32'b10);
    check("fetch_mem_addr", mem_addr, 32'h10);
    step();
    check("fetch_ack", 32'({i_ack, i_err}), 32'b10);
    check("fetch_rdata", i_rdata, 32'hDEADBEEF);
    i_req = 1'b0;
    step();
    check("fetch_ack_one_cycle", 32'(i_ack), 32'd0);
    check("rdata_holds", i_rdata, 32'hDEADBEEF);
    step();

    // Simultaneous after reset: D store wins, latency 3
    lat = 3;
    i_req = 1'b1; i_addr = 32'h0;
    d_req = 1'b1; d_addr = 32'h20; d_wdata = 32'h55; d_we = 1'b1; d_mode = 2'b10;
    push_g(32'h20, 32'h55, 1'b1, 2'b10, 3);
    push_g(32'h0, 32'h0, 1'b0, 2'b10, 3);
    push_a(1'b1, 1'b0, rd(32'h20));
    push_a(1'b0, 1'b0, rd(32'h0));
    step();
    check("sim_d_first", 32'({mem_req, mem_we}), 32'b11);
    check("sim_d_wdata", mem_wdata, 32'h55);
    step(); step();
    check("sim_no_ack_yet", 32'({i_ack, d_ack}), 32'd0);
    step();
    check("sim_d_ack_4", 32'({i_ack, d_ack}), 32'b01);
    d_req = 1'b0;
    step();
    check("sim_i_mem_req", 32'({mem_req, mem_we}), 32'b10);
    check("sim_i_addr", mem_addr, 32'h0);
    wait_ack(1'b0, 10, "sim_i_ack_seen");
    i_req = 1'b0;
    step();

    // Round-robin: both held for 8 transactions, latency 1
    lat = 1;
    i_addr = 32'h100;
    d_addr = 32'h200; d_wdata = 32'hA5; d_we = 1'b0; d_mode = 2'b01;
    for (int k = 0; k < 4; k++) begin
      push_g(32'h200, 32'hA5, 1'b0, 2'b01, 1);
      push_a(1'b1, 1'b0, rd(32'h200));
      push_g(32'h100, 32'h0, 1'b0, 2'b10, 1);
      push_a(1'b0, 1'b0, rd(32'h100));
    end
    i_req = 1'b1; d_req = 1'b1;
    ic = 0; dc = 0;
    for (int c = 0; c < 200 && (i_req || d_req); c++) begin
      step();
      if (d_ack) begin dc++; if (dc == 4) d_req = 1'b0; end
      if (i_ack) begin ic++; if (ic == 4) i_req = 1'b0; end
    end
    check("rr_i_count", 32'(ic), 32'd4);
    check("rr_d_count", 32'(dc), 32'd4);
    i_req = 1'b0; d_req = 1'b0;
    step();

    // Timeout: memory never acks
    lat = 0;
    d_req = 1'b1; d_addr = 32'h300; d_wdata = 32'h1234; d_we = 1'b0; d_mode = 2'b00;
    push_g(32'h300, 32'h1234, 1'b0, 2'b00, 4);
    push_a(1'b1, 1'b1, 32'h0);
    wait_ack(1'b1, 10, "tmo_ack_seen");
    check("tmo_err", 32'({d_err, mem_req}), 32'b10);
    check("tmo_rdata", d_rdata, 32'h0);
    d_req = 1'b0;
    step();
    check("tmo_idle", 32'(mem_req), 32'd0);

    // Fetch served normally after the timeout
    lat = 2;
    i_req = 1'b1; i_addr = 32'h40;
    push_g(32'h40, 32'h0, 1'b0, 2'b10, 2);
    push_a(1'b0, 1'b0, rd(32'h40));
    wait_ack(1'b0, 10, "post_tmo_ack_seen");
    check("post_tmo_rdata", i_rdata, 32'hDEADBEBF);
    i_req = 1'b0;
    step();

    // Reset mid-transaction in BUSY_I
    lat = 0;
    i_req = 1'b1; i_addr = 32'h50;
    push_g(32'h50, 32'h0, 1'b0, 2'b10, 0);
    step(); step();
    check("busy_before_reset", 32'(mem_req), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("reset_drops_mem_req", 32'(mem_req), 32'd0);
    check("reset_no_ack", 32'(i_ack), 32'd0);
    i_req = 1'b0;
    step();
    reset = 1'b0;
    step(); step();

    // After reset, simultaneous requests grant D first
    lat = 1;
    i_addr = 32'h60;
    d_addr = 32'h70; d_wdata = 32'h9; d_we = 1'b1; d_mode = 2'b10;
    push_g(32'h70, 32'h9, 1'b1, 2'b10, 1);
    push_a(1'b1, 1'b0, rd(32'h70));
    push_g(32'h60, 32'h0, 1'b0, 2'b10, 1);
    push_a(1'b0, 1'b0, rd(32'h60));
    i_req = 1'b1; d_req = 1'b1;
    wait_ack(1'b1, 10, "rst_d_ack_seen");
    d_req = 1'b0;
    wait_ack(1'b0, 10, "rst_i_ack_seen");
    i_req = 1'b0;
    step(); step(); step();

    check("grant_queue_drained", 32'(gq.size()), 32'd0);
    check("ack_queue_drained", 32'(aq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
